fetch_prefetch_unit: RTL and testbench

//  Parametrised IF stage replacing the fixed PC register + IF/ID register pair of the pipeline CPU.

---
 rtl/fetch_prefetch_unit_pkg.sv | 14 +
 rtl/fetch_prefetch_unit_fifo.sv | 52 +++++
 rtl/fetch_prefetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and the fetch-entry payload for the IF-stage prefetch unit.
package fetch_prefetch_unit_pkg;

    localparam int unsigned     XLEN_DEF     = 32;
    localparam int unsigned     ILEN         = 32;
    localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN-1:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Circular prefetch buffer holding {pc, instr} words; flush wins over push.
module fetch_prefetch_unit_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [W-1:0]            i_data,
    input  logic                    i_pop,
    input  logic                    i_flush,
    output logic [W-1:0]            o_head,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned     AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW   = $clog2(DEPTH) + 1;
    localparam int unsigned     NMEM = 2 ** AW;
    localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

    logic [W-1:0]  r_mem [NMEM];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= ptr_inc(r_wr);
            if (i_pop)  r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !reset) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage: owns the PC, streams reads to a 1-cycle ROM and queues words for ID.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter bit              BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [ILEN-1:0]         imem_rdata,
    input  logic                    id_ready,
    output logic                    if_valid,
    output logic [ILEN-1:0]         if_instr,
    output logic [XLEN-1:0]         if_pc,
    output logic [XLEN-1:0]         if_pcplus4,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]  fq_count
);

    localparam int unsigned     CW         = $clog2(DEPTH) + 1;
    localparam int unsigned     SW         = CW + 1;
    localparam int unsigned     EW         = XLEN + ILEN;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_inflight;
    logic            r_kill;

    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic            w_empty;
    logic            w_space;
    logic            w_resp;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_out_pc;
    logic [ILEN-1:0] w_out_instr;

    // Reserve a slot for the inflight word so a response never meets a full queue.
    assign w_empty   = (w_count == '0);
    assign w_space   = ({1'b0, w_count} + SW'(r_inflight)) < SW'(DEPTH);
    assign imem_req  = ~reset & ~redirect_valid & w_space;
    assign imem_addr = r_pc;

    assign w_resp    = r_inflight & ~r_kill;
    assign w_bypass  = BYPASS & w_resp & w_empty;
    assign if_valid  = ~reset & (~w_empty | w_bypass);
    assign w_pop     = if_valid & id_ready & ~w_empty;
    assign w_push    = w_resp & ~(w_bypass & id_ready);

    assign w_out_pc    = w_empty ? r_resp_pc  : w_head[EW-1 -: XLEN];
    assign w_out_instr = w_empty ? imem_rdata : w_head[ILEN-1:0];
    assign if_instr    = if_valid ? w_out_instr : NOP_INSTR;
    assign if_pc       = w_out_pc;
    assign if_pcplus4  = w_out_pc + PC_STEP;
    assign fq_count    = w_count;

    fetch_prefetch_unit_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_resp_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // PC and response tracking; a redirect suppresses whatever was still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc & ALIGN_MASK;
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_inflight <= imem_req;
            r_kill     <= 1'b0;
            if (imem_req) begin
                r_pc      <= r_pc + PC_STEP;
                r_resp_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for three fetch-unit configurations sharing one stimulus stream.
module tb_fetch_prefetch_unit;
    import fetch_prefetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req   [3];
    logic [31:0] imem_addr  [3];
    logic [31:0] imem_rdata [3];
    logic        if_valid   [3];
    logic [31:0] if_instr   [3];
    logic [31:0] if_pc      [3];
    logic [31:0] if_pcplus4 [3];
    logic [2:0]  fq_count   [3];

    fetch_entry_t sb_q [3][$];
    int  npop [3] = '{0, 0, 0};
    int  total = 0;
    int  bad   = 0;
    bit  done  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=4 BYPASS=1, instance 1: DEPTH=4 BYPASS=0, instance 2: DEPTH=1 BYPASS=1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned GD = (g == 2) ? 1 : 4;
        localparam bit          GB = (g == 1) ? 1'b0 : 1'b1;
        logic [$clog2(GD):0] w_cnt;

        fetch_prefetch_unit #(
            .XLEN     (32),
            .DEPTH    (GD),
            .RESET_PC (32'h0000_0000),
            .BYPASS   (GB)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .imem_req       (imem_req[g]),
            .imem_addr      (imem_addr[g]),
            .imem_rdata     (imem_rdata[g]),
            .id_ready       (id_ready),
            .if_valid       (if_valid[g]),
            .if_instr       (if_instr[g]),
            .if_pc          (if_pc[g]),
            .if_pcplus4     (if_pcplus4[g]),
            .redirect_valid (redirect_valid),
            .redirect_pc    (redirect_pc),
            .fq_count       (w_cnt)
        );
        assign fq_count[g] = 3'(w_cnt);
    end

    // ROM content is the word index of the address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) imem_rdata[i] <= imem_addr[i] >> 2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic restart_stream(input logic [31:0] base);
        fetch_entry_t e;
        for (int i = 0; i < 3; i++) begin
            sb_q[i].delete();
            for (int k = 0; k < 48; k++) begin
                e.pc    = base + 32'(4 * k);
                e.instr = e.pc >> 2;
                sb_q[i].push_back(e);
            end
        end
    endtask

    task automatic window(input int e0, input int e1, input int e2);
        int p [3];
        for (int i = 0; i < 3; i++) p[i] = npop[i];
        repeat (10) step();
        check("throughput_0", 32'(npop[0] - p[0]), 32'(e0));
        check("throughput_1", 32'(npop[1] - p[1]), 32'(e1));
        check("throughput_2", 32'(npop[2] - p[2]), 32'(e2));
    endtask

    task automatic monitor_loop();
        fetch_entry_t e;
        while (!done) begin
            at_neg();
            if (!reset && !redirect_valid) begin
                for (int i = 0; i < 3; i++) begin
                    if (!if_valid[i]) begin
                        check($sformatf("nop_%0d", i), if_instr[i], 32'h0);
                    end else if (sb_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_empty_%0d: got pc 0x%0h expected no word", i, if_pc[i]);
                    end else begin
                        e = sb_q[i][0];
                        check($sformatf("instr_%0d", i), if_instr[i], e.instr);
                        check($sformatf("pc_%0d", i), if_pc[i], e.pc);
                        check($sformatf("pcplus4_%0d", i), if_pcplus4[i], e.pc + 32'd4);
                        if (id_ready) begin
                            e = sb_q[i].pop_front();
                            npop[i]++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset state
        repeat (3) step();
        at_neg();
        check("rst_req", 32'(imem_req[0]), 32'd0);
        check("rst_valid", 32'(if_valid[0]), 32'd0);
        check("rst_instr", if_instr[0], 32'h0);
        check("rst_count", 32'(fq_count[0]), 32'd0);
        check("rst_valid_1", 32'(if_valid[1]), 32'd0);

        // Streaming from reset
        restart_stream(32'h0);
        step(); reset = 1'b0; id_ready = 1'b1;
        at_neg();
        check("c0_req", 32'(imem_req[0]), 32'd1);
        check("c0_addr", imem_addr[0], 32'h0);
        check("c0_valid", 32'(if_valid[0]), 32'd0);
        step();
        at_neg();
        check("c1_addr", imem_addr[0], 32'h4);
        check("c1_valid", 32'(if_valid[0]), 32'd1);
        check("c1_valid_nobyp", 32'(if_valid[1]), 32'd0);
        check("c1_req_d1", 32'(imem_req[2]), 32'd0);
        step();
        at_neg();
        check("c2_valid_nobyp", 32'(if_valid[1]), 32'd1);
        check("c2_req_d1", 32'(imem_req[2]), 32'd1);
        check("c2_addr_d1", imem_addr[2], 32'h4);
        step();
        window(10, 10, 5);

        // Stall until the queue fills, then release
        id_ready = 1'b0;
        repeat (9) step();
        at_neg();
        check("stall_count", 32'(fq_count[0]), 32'd4);
        check("stall_req", 32'(imem_req[0]), 32'd0);
        check("stall_count_1", 32'(fq_count[1]), 32'd4);
        check("stall_count_2", 32'(fq_count[2]), 32'd1);
        check("stall_valid", 32'(if_valid[0]), 32'd1);
        step(); id_ready = 1'b1;
        window(10, 10, 5);

        // Redirect with a response in flight
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        at_neg();
        check("redir_req", 32'(imem_req[0]), 32'd0);
        step(); redirect_valid = 1'b0; restart_stream(32'h100);
        at_neg();
        check("redir_addr", imem_addr[0], 32'h100);
        check("redir_req_next", 32'(imem_req[0]), 32'd1);
        check("redir_count", 32'(fq_count[0]), 32'd0);
        check("redir_valid", 32'(if_valid[0]), 32'd0);
        step();
        at_neg();
        check("redir_first_valid", 32'(if_valid[0]), 32'd1);
        check("redir_first_pc", if_pc[0], 32'h100);
        check("redir_first_instr", if_instr[0], 32'h40);
        repeat (8) step();

        // Back-to-back redirects
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); redirect_pc = 32'h300;
        at_neg();
        check("b2b_count_a", 32'(fq_count[0]), 32'd0);
        check("b2b_req", 32'(imem_req[0]), 32'd0);
        step(); redirect_valid = 1'b0; restart_stream(32'h300);
        at_neg();
        check("b2b_count_b", 32'(fq_count[0]), 32'd0);
        check("b2b_addr", imem_addr[0], 32'h300);
        repeat (8) step();

        // Address wrap and misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step(); redirect_valid = 1'b0; restart_stream(32'hFFFF_FFF8);
        at_neg();
        check("wrap_addr_a", imem_addr[0], 32'hFFFF_FFF8);
        step();
        at_neg();
        check("wrap_addr_b", imem_addr[0], 32'hFFFF_FFFC);
        step();
        at_neg();
        check("wrap_addr_c", imem_addr[0], 32'h0);
        repeat (6) step();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step(); redirect_valid = 1'b0; restart_stream(32'h100);
        at_neg();
        check("align_addr", imem_addr[0], 32'h100);
        step();
        at_neg();
        check("align_pc", if_pc[0], 32'h100);
        repeat (7) step();

        // Reset with three queued words and one in flight
        id_ready = 1'b0;
        step();
        step();
        step(); reset = 1'b1;
        at_neg();
        check("midrst_count_before", 32'(fq_count[0]), 32'd3);
        step(); reset = 1'b0; id_ready = 1'b1; restart_stream(32'h0);
        at_neg();
        check("midrst_valid", 32'(if_valid[0]), 32'd0);
        check("midrst_count", 32'(fq_count[0]), 32'd0);
        check("midrst_addr", imem_addr[0], 32'h0);
        check("midrst_req", 32'(imem_req[0]), 32'd1);
        step();
        at_neg();
        check("midrst_first_valid", 32'(if_valid[0]), 32'd1);
        check("midrst_first_pc", if_pc[0], 32'h0);
        repeat (10) step();
        done = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fork
            monitor_loop();
            stimulus();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
